scic_control_unit: RTL

- Control-unit FSM for the SCIC accumulator computer. It sequences the datapath (PC, IR, memory, ACC/ALU, switch input, LED output register) through fetch/decode/execute.
- Takes the current opcode and ACC flags as inputs and drives every datapath enable and select.
- Counts retired instructions for debug.
- Sits between the top-level SCIC wrapper and the existing datapath; a nominal instruction takes 3 clocks.

---
 rtl/scic_pkg.sv | 33 +++
 rtl/scic_retire_counter.sv | 18 +
 rtl/scic_control_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/scic_pkg.sv
// Shared types and constants for the SCIC control unit: FSM states, opcodes, ALU selects.
package scic_pkg;

    localparam int unsigned OPC_W_DEF = 4;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_JZ    = 4'h5;
    localparam logic [3:0] OP_JN    = 4'h6;
    localparam logic [3:0] OP_IN    = 4'h7;
    localparam logic [3:0] OP_OUT   = 4'h8;
    localparam logic [3:0] OP_AND   = 4'h9;
    localparam logic [3:0] OP_OR    = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_PASS_MEM = 3'd0;
    localparam logic [2:0] ALU_ADD      = 3'd1;
    localparam logic [2:0] ALU_SUB      = 3'd2;
    localparam logic [2:0] ALU_AND      = 3'd3;
    localparam logic [2:0] ALU_OR       = 3'd4;
    localparam logic [2:0] ALU_PASS_SW  = 3'd5;

endpackage

// File: rtl/scic_retire_counter.sv
// Retired-instruction counter: enable-increment, wraps modulo 2^CNT_W, async active-low clear.
module scic_retire_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/scic_control_unit.sv
// SCIC control-unit FSM (FETCH/DECODE/EXECUTE/HALT) driving all datapath enables and selects.
// Optional single-step gating of FETCH is enabled by defining SCIC_SINGLE_STEP_EN.
module scic_control_unit
    import scic_pkg::*;
#(
    parameter int unsigned OPC_W = OPC_W_DEF,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             acc_zero,
    input  logic             acc_neg,
    input  logic             mem_ready,
`ifdef SCIC_SINGLE_STEP_EN
    input  logic             step,
    output logic             step_wait,
`endif
    output logic             pc_inc,
    output logic             pc_load,
    output logic             ir_load,
    output logic             addr_sel,
    output logic             mem_write,
    output logic             acc_load,
    output logic [2:0]       alu_op,
    output logic             led_load,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t     state, state_next;
    logic [3:0] op;
    logic       exec_done;
    logic       fetch_go;
    logic       retire;

    assign op = 4'(opcode);

`ifdef SCIC_SINGLE_STEP_EN
    logic step_q;
    logic step_pending;
    logic step_rise;

    assign step_rise = step & ~step_q;
    assign fetch_go  = step_pending;

    // A rising edge arms exactly one fetch; the arm is consumed when that fetch completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_q       <= 1'b0;
            step_pending <= 1'b0;
        end else begin
            step_q <= step;
            if (step_rise)
                step_pending <= 1'b1;
            else if (state == FETCH && mem_ready)
                step_pending <= 1'b0;
        end
    end

    assign step_wait = reset && (state == FETCH) && !step_pending;
`else
    assign fetch_go = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        exec_done  = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        ir_load    = 1'b0;
        addr_sel   = 1'b0;
        mem_write  = 1'b0;
        acc_load   = 1'b0;
        alu_op     = ALU_PASS_MEM;
        led_load   = 1'b0;
        halted     = 1'b0;

        case (state)
            FETCH: begin
                if (fetch_go) begin
                    ir_load = mem_ready;
                    pc_inc  = mem_ready;
                    if (mem_ready)
                        state_next = DECODE;
                end
            end
            DECODE: begin
                addr_sel   = 1'b1;
                state_next = EXECUTE;
            end
            EXECUTE: begin
                case (op)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        addr_sel  = 1'b1;
                        acc_load  = mem_ready;
                        exec_done = mem_ready;
                        case (op)
                            OP_ADD:  alu_op = ALU_ADD;
                            OP_SUB:  alu_op = ALU_SUB;
                            OP_AND:  alu_op = ALU_AND;
                            OP_OR:   alu_op = ALU_OR;
                            default: alu_op = ALU_PASS_MEM;
                        endcase
                    end
                    OP_STORE: begin
                        addr_sel  = 1'b1;
                        mem_write = 1'b1;
                        exec_done = mem_ready;
                    end
                    OP_JMP: begin
                        pc_load   = 1'b1;
                        exec_done = 1'b1;
                    end
                    OP_JZ: begin
                        pc_load   = acc_zero;
                        exec_done = 1'b1;
                    end
                    OP_JN: begin
                        pc_load   = acc_neg;
                        exec_done = 1'b1;
                    end
                    OP_IN: begin
                        alu_op    = ALU_PASS_SW;
                        acc_load  = 1'b1;
                        exec_done = 1'b1;
                    end
                    OP_OUT: begin
                        led_load  = 1'b1;
                        exec_done = 1'b1;
                    end
                    default: exec_done = 1'b1;
                endcase
                if (exec_done)
                    state_next = (op == OP_HALT) ? HALT : FETCH;
            end
            HALT: halted = 1'b1;
            default: state_next = FETCH;
        endcase

        // Reset forces every output low at once, so no write can complete once it asserts.
        if (!reset) begin
            exec_done = 1'b0;
            pc_inc    = 1'b0;
            pc_load   = 1'b0;
            ir_load   = 1'b0;
            addr_sel  = 1'b0;
            mem_write = 1'b0;
            acc_load  = 1'b0;
            alu_op    = ALU_PASS_MEM;
            led_load  = 1'b0;
            halted    = 1'b0;
        end
    end

    assign retire = (state == EXECUTE) && exec_done;

    scic_retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clock(clock),
        .reset(reset),
        .en   (retire),
        .count(retired)
    );

endmodule
